rs_multi_cdb: RTL and testbench

//  Parametrised reservation station for ALU/branch ops in the Tomasulo core. Sits between dispatch and EX.

---
 rtl/rs_pkg.sv | 21 ++
 rtl/rs_prio_enc.sv | 23 ++
 rtl/rs_multi_cdb.sv | 199 +++++++++++++++++++
 tb/tb_rs_multi_cdb.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared helpers and default sizing for the reservation station.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: default parameter values and the offset helper used to pull
// channel k out of a flattened per-channel CDB bus.
package rs_pkg;

  localparam int unsigned RS_DEPTH_DEF  = 16;
  localparam int unsigned RS_TAG_W_DEF  = 4;
  localparam int unsigned RS_DATA_W_DEF = 32;
  localparam int unsigned RS_ADDR_W_DEF = 32;
  localparam int unsigned RS_IMM_W_DEF  = 32;
  localparam int unsigned RS_OP_W_DEF   = 6;
  localparam int unsigned RS_CDB_N_DEF  = 2;

  // Bit offset of channel k inside a flattened bus of w-bit fields.
  function automatic int unsigned cdb_off(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-set-bit priority encoder with an any-valid flag.
// Latency: combinational.
// Backpressure: none.
// Ports: req (W request bits), idx (index of lowest set bit, 0 when none), any (|req).
module rs_prio_enc #(
  parameter  int unsigned W  = 16,
  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    idx = '0;
    any = |req;
    // Walk downward so the lowest set bit is the last one written.
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/rs_multi_cdb.sv
// Reservation station for ALU/branch ops with CDB_N wakeup channels and a registered EX issue slot.
// Latency: entry written at edge t issues at edge t+1 earliest; wakeup-to-issue 1 edge (0 with RS_WAKEUP_BYPASS_EN).
// Backpressure: oEX_* hold while oEX_en & !iEX_ready; oINF_full is registered one cycle ahead of the last free slot.
// Ports: clk/rst (sync, active-high)/rdy (global enable)/clr (flush); iDP_* dispatch; iCDB_* flattened
// broadcast channels (channel k at [k*W +: W]); iEX_ready/oEX_* issue slot; oINF_full dispatch stop.
// Optional macro RS_WAKEUP_BYPASS_EN: select also sees operands arriving on the CDB this cycle.
module rs_multi_cdb
  import rs_pkg::*;
#(
  parameter int unsigned DEPTH  = RS_DEPTH_DEF,
  parameter int unsigned TAG_W  = RS_TAG_W_DEF,
  parameter int unsigned DATA_W = RS_DATA_W_DEF,
  parameter int unsigned ADDR_W = RS_ADDR_W_DEF,
  parameter int unsigned IMM_W  = RS_IMM_W_DEF,
  parameter int unsigned OP_W   = RS_OP_W_DEF,
  parameter int unsigned CDB_N  = RS_CDB_N_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    clr,
  output logic                    oINF_full,
  input  logic                    iDP_en,
  input  logic [OP_W-1:0]         iDP_op,
  input  logic [ADDR_W-1:0]       iDP_pc,
  input  logic [IMM_W-1:0]        iDP_imm,
  input  logic [TAG_W-1:0]        iDP_rd_nick,
  input  logic [TAG_W-1:0]        iDP_rs1_nick,
  input  logic [DATA_W-1:0]       iDP_rs1_dt,
  input  logic [TAG_W-1:0]        iDP_rs2_nick,
  input  logic [DATA_W-1:0]       iDP_rs2_dt,
  input  logic [CDB_N-1:0]        iCDB_en,
  input  logic [CDB_N*TAG_W-1:0]  iCDB_nick,
  input  logic [CDB_N*DATA_W-1:0] iCDB_dt,
  input  logic                    iEX_ready,
  output logic                    oEX_en,
  output logic [OP_W-1:0]         oEX_op,
  output logic [ADDR_W-1:0]       oEX_pc,
  output logic [IMM_W-1:0]        oEX_imm,
  output logic [TAG_W-1:0]        oEX_rd_nick,
  output logic [DATA_W-1:0]       oEX_rs1_dt,
  output logic [DATA_W-1:0]       oEX_rs2_dt
);

  localparam int unsigned IW = $clog2(DEPTH);

  typedef struct packed {
    logic              occ;
    logic              v1;
    logic              v2;
    logic [TAG_W-1:0]  n1;
    logic [TAG_W-1:0]  n2;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] pc;
    logic [IMM_W-1:0]  imm;
    logic [TAG_W-1:0]  rd;
  } ent_t;

  typedef struct packed {
    logic              en;
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] pc;
    logic [IMM_W-1:0]  imm;
    logic [TAG_W-1:0]  rd;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
  } ex_t;

  ent_t ent_q [DEPTH];
  ent_t ent_d [DEPTH];
  ex_t  ex_q, ex_d;
  logic full_q, full_d;

  logic              hit1 [DEPTH];
  logic              hit2 [DEPTH];
  logic [DATA_W-1:0] wd1  [DEPTH];
  logic [DATA_W-1:0] wd2  [DEPTH];
  logic              dp_hit1, dp_hit2;
  logic [DATA_W-1:0] dp_wd1, dp_wd2;
  logic [DEPTH-1:0]  free_vec, rdy_vec;
  logic [IW-1:0]     alloc_idx, sel_idx;
  logic              alloc_any, sel_any;
  logic              slot_free;
  logic [DATA_W-1:0] iss_d1, iss_d2;
  int unsigned       cnt;

  // Search all enabled channels for a nonzero nick; the lowest channel wins on duplicates.
  function automatic logic cdb_lookup(input logic [TAG_W-1:0] nick, output logic [DATA_W-1:0] dat);
    logic hit;
    hit = 1'b0;
    dat = '0;
    for (int k = int'(CDB_N) - 1; k >= 0; k--) begin
      if (iCDB_en[k] && (nick != '0) && (iCDB_nick[cdb_off(k, TAG_W) +: TAG_W] == nick)) begin
        hit = 1'b1;
        dat = iCDB_dt[cdb_off(k, DATA_W) +: DATA_W];
      end
    end
    return hit;
  endfunction

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      hit1[i]     = cdb_lookup(ent_q[i].n1, wd1[i]);
      hit2[i]     = cdb_lookup(ent_q[i].n2, wd2[i]);
      free_vec[i] = !ent_q[i].occ;
`ifdef RS_WAKEUP_BYPASS_EN
      rdy_vec[i]  = ent_q[i].occ && (ent_q[i].v1 || hit1[i]) && (ent_q[i].v2 || hit2[i]);
`else
      rdy_vec[i]  = ent_q[i].occ && ent_q[i].v1 && ent_q[i].v2;
`endif
    end
    dp_hit1 = cdb_lookup(iDP_rs1_nick, dp_wd1);
    dp_hit2 = cdb_lookup(iDP_rs2_nick, dp_wd2);
  end

  rs_prio_enc #(.W(DEPTH)) u_alloc_enc (.req(free_vec), .idx(alloc_idx), .any(alloc_any));
  rs_prio_enc #(.W(DEPTH)) u_sel_enc   (.req(rdy_vec),  .idx(sel_idx),   .any(sel_any));

  always_comb begin
    ent_d     = ent_q;
    ex_d      = ex_q;
    full_d    = full_q;
    cnt       = 0;
    slot_free = !ex_q.en || iEX_ready;
`ifdef RS_WAKEUP_BYPASS_EN
    iss_d1 = ent_q[sel_idx].v1 ? ent_q[sel_idx].d1 : wd1[sel_idx];
    iss_d2 = ent_q[sel_idx].v2 ? ent_q[sel_idx].d2 : wd2[sel_idx];
`else
    iss_d1 = ent_q[sel_idx].d1;
    iss_d2 = ent_q[sel_idx].d2;
`endif
    if (rdy) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (ent_q[i].occ && !ent_q[i].v1 && hit1[i]) begin
          ent_d[i].v1 = 1'b1;
          ent_d[i].d1 = wd1[i];
        end
        if (ent_q[i].occ && !ent_q[i].v2 && hit2[i]) begin
          ent_d[i].v2 = 1'b1;
          ent_d[i].d2 = wd2[i];
        end
      end
      // Dispatch only targets a slot that was free at cycle start, so it never collides with issue.
      if (iDP_en && !full_q && alloc_any) begin
        ent_d[alloc_idx].occ = 1'b1;
        ent_d[alloc_idx].v1  = dp_hit1 || (iDP_rs1_nick == '0);
        ent_d[alloc_idx].v2  = dp_hit2 || (iDP_rs2_nick == '0);
        ent_d[alloc_idx].n1  = iDP_rs1_nick;
        ent_d[alloc_idx].n2  = iDP_rs2_nick;
        ent_d[alloc_idx].d1  = dp_hit1 ? dp_wd1 : iDP_rs1_dt;
        ent_d[alloc_idx].d2  = dp_hit2 ? dp_wd2 : iDP_rs2_dt;
        ent_d[alloc_idx].op  = iDP_op;
        ent_d[alloc_idx].pc  = iDP_pc;
        ent_d[alloc_idx].imm = iDP_imm;
        ent_d[alloc_idx].rd  = iDP_rd_nick;
      end
      if (slot_free) begin
        ex_d.en = sel_any;
        if (sel_any) begin
          ex_d.op  = ent_q[sel_idx].op;
          ex_d.pc  = ent_q[sel_idx].pc;
          ex_d.imm = ent_q[sel_idx].imm;
          ex_d.rd  = ent_q[sel_idx].rd;
          ex_d.d1  = iss_d1;
          ex_d.d2  = iss_d2;
          ent_d[sel_idx].occ = 1'b0;
        end
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
        cnt = cnt + (ent_d[i].occ ? 32'd1 : 32'd0);
      end
      full_d = (cnt >= DEPTH - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= '0;
      ex_q   <= '0;
      full_q <= 1'b0;
    end else begin
      ent_q  <= ent_d;
      ex_q   <= ex_d;
      full_q <= full_d;
    end
  end

  assign oINF_full   = full_q;
  assign oEX_en      = ex_q.en;
  assign oEX_op      = ex_q.op;
  assign oEX_pc      = ex_q.pc;
  assign oEX_imm     = ex_q.imm;
  assign oEX_rd_nick = ex_q.rd;
  assign oEX_rs1_dt  = ex_q.d1;
  assign oEX_rs2_dt  = ex_q.d2;

endmodule

// File: tb/tb_rs_multi_cdb.sv
// Directed bench for rs_multi_cdb: table of single-cycle vectors plus hand sequences
// for reset/flush, wakeup, backpressure, full and freeze.
module tb_rs_multi_cdb;

  logic        clk = 1'b0;
  logic        rst, rdy, clr;
  logic        oINF_full;
  logic        iDP_en;
  logic [5:0]  iDP_op;
  logic [31:0] iDP_pc, iDP_imm;
  logic [3:0]  iDP_rd_nick, iDP_rs1_nick, iDP_rs2_nick;
  logic [31:0] iDP_rs1_dt, iDP_rs2_dt;
  logic [1:0]  iCDB_en;
  logic [7:0]  iCDB_nick;
  logic [63:0] iCDB_dt;
  logic        iEX_ready;
  logic        oEX_en;
  logic [5:0]  oEX_op;
  logic [31:0] oEX_pc, oEX_imm;
  logic [3:0]  oEX_rd_nick;
  logic [31:0] oEX_rs1_dt, oEX_rs2_dt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rs_multi_cdb dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .oINF_full(oINF_full),
    .iDP_en(iDP_en), .iDP_op(iDP_op), .iDP_pc(iDP_pc), .iDP_imm(iDP_imm),
    .iDP_rd_nick(iDP_rd_nick), .iDP_rs1_nick(iDP_rs1_nick), .iDP_rs1_dt(iDP_rs1_dt),
    .iDP_rs2_nick(iDP_rs2_nick), .iDP_rs2_dt(iDP_rs2_dt),
    .iCDB_en(iCDB_en), .iCDB_nick(iCDB_nick), .iCDB_dt(iCDB_dt),
    .iEX_ready(iEX_ready), .oEX_en(oEX_en), .oEX_op(oEX_op), .oEX_pc(oEX_pc),
    .oEX_imm(oEX_imm), .oEX_rd_nick(oEX_rd_nick), .oEX_rs1_dt(oEX_rs1_dt), .oEX_rs2_dt(oEX_rs2_dt)
  );

  typedef struct {
    logic        dp;
    logic [3:0]  rd, n1;
    logic [31:0] d1;
    logic [3:0]  n2;
    logic [31:0] d2;
    logic [1:0]  cen;
    logic [3:0]  cn0;
    logic [31:0] cd0;
    logic [3:0]  cn1;
    logic [31:0] cd1;
    logic        x_en;
    logic [3:0]  x_rd;
    logic [31:0] x_d1, x_d2;
  } vec_t;

  vec_t tbl [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iDP_en = 1'b0; iDP_op = '0; iDP_pc = '0; iDP_imm = '0; iDP_rd_nick = '0;
    iDP_rs1_nick = '0; iDP_rs1_dt = '0; iDP_rs2_nick = '0; iDP_rs2_dt = '0;
    iCDB_en = '0; iCDB_nick = '0; iCDB_dt = '0;
  endtask

  task automatic dp(input logic [3:0] rd, input logic [3:0] n1, input logic [31:0] d1,
                    input logic [3:0] n2, input logic [31:0] d2);
    iDP_en = 1'b1; iDP_op = 6'h01;
    iDP_pc = 32'h1000 + {28'd0, rd}; iDP_imm = {26'd0, rd, 2'b00};
    iDP_rd_nick = rd; iDP_rs1_nick = n1; iDP_rs1_dt = d1; iDP_rs2_nick = n2; iDP_rs2_dt = d2;
  endtask

  task automatic cdb(input int ch, input logic [3:0] n, input logic [31:0] d);
    iCDB_en[ch] = 1'b1;
    iCDB_nick[ch*4 +: 4] = n;
    iCDB_dt[ch*32 +: 32] = d;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_ex(input string nm, input logic [3:0] rd, input logic [31:0] d1, input logic [31:0] d2);
    chk({nm, "_en"}, 64'(oEX_en), 64'd1);
    chk({nm, "_rd"}, 64'(oEX_rd_nick), 64'(rd));
    chk({nm, "_d1"}, 64'(oEX_rs1_dt), 64'(d1));
    chk({nm, "_d2"}, 64'(oEX_rs2_dt), 64'(d2));
    chk({nm, "_pc"}, 64'(oEX_pc), 64'(32'h1000 + {28'd0, rd}));
    chk({nm, "_imm"}, 64'(oEX_imm), 64'({26'd0, rd, 2'b00}));
    chk({nm, "_op"}, 64'(oEX_op), 64'd1);
  endtask

  initial begin
    //          dp  rd    n1    d1        n2    d2        cen    cn0   cd0        cn1   cd1        x_en  x_rd  x_d1      x_d2
    tbl[0] = '{1'b1, 4'd3, 4'd0, 32'h5,    4'd0, 32'h7,    2'b00, 4'd0, 32'h0,     4'd0, 32'h0,     1'b0, 4'd0, 32'h0,    32'h0};
    tbl[1] = '{1'b1, 4'd4, 4'd0, 32'h1,    4'd0, 32'h2,    2'b00, 4'd0, 32'h0,     4'd0, 32'h0,     1'b1, 4'd3, 32'h5,    32'h7};
    tbl[2] = '{1'b1, 4'd6, 4'd0, 32'h22,   4'd4, 32'h99,   2'b01, 4'd4, 32'h11,    4'd0, 32'h0,     1'b1, 4'd4, 32'h1,    32'h2};
    tbl[3] = '{1'b0, 4'd0, 4'd0, 32'h0,    4'd0, 32'h0,    2'b00, 4'd0, 32'h0,     4'd0, 32'h0,     1'b1, 4'd6, 32'h22,   32'h11};
    tbl[4] = '{1'b1, 4'd8, 4'd5, 32'h999,  4'd0, 32'h3,    2'b11, 4'd0, 32'hBAD,   4'd5, 32'h55,    1'b0, 4'd0, 32'h0,    32'h0};
    tbl[5] = '{1'b0, 4'd0, 4'd0, 32'h0,    4'd0, 32'h0,    2'b00, 4'd0, 32'h0,     4'd0, 32'h0,     1'b1, 4'd8, 32'h55,   32'h3};
    tbl[6] = '{1'b1, 4'd9, 4'd2, 32'h0,    4'd2, 32'h0,    2'b11, 4'd2, 32'hA0,    4'd2, 32'hB0,    1'b0, 4'd0, 32'h0,    32'h0};
    tbl[7] = '{1'b0, 4'd0, 4'd0, 32'h0,    4'd0, 32'h0,    2'b00, 4'd0, 32'h0,     4'd0, 32'h0,     1'b1, 4'd9, 32'hA0,   32'hA0};
    tbl[8] = '{1'b0, 4'd0, 4'd0, 32'h0,    4'd0, 32'h0,    2'b00, 4'd0, 32'h0,     4'd0, 32'h0,     1'b0, 4'd0, 32'h0,    32'h0};

    // T1: reset, then flush (with rdy low) over 3 loaded entries.
    idle(); rst = 1'b1; rdy = 1'b1; clr = 1'b0; iEX_ready = 1'b0;
    tick(); tick();
    chk("rst_outs_zero", 64'(|{oEX_en, oEX_op, oEX_pc, oEX_imm, oEX_rd_nick, oEX_rs1_dt, oEX_rs2_dt}), 64'd0);
    chk("rst_full", 64'(oINF_full), 64'd0);
    rst = 1'b0;
    dp(4'd1, 4'd0, 32'h10, 4'd0, 32'h20); tick();
    dp(4'd2, 4'd0, 32'h30, 4'd0, 32'h40); tick();
    dp(4'd3, 4'd0, 32'h50, 4'd0, 32'h60); tick();
    idle();
    chk_ex("t1_loaded", 4'd1, 32'h10, 32'h20);
    clr = 1'b1; rdy = 1'b0; tick();
    chk("clr_outs_zero", 64'(|{oEX_en, oEX_op, oEX_pc, oEX_imm, oEX_rd_nick, oEX_rs1_dt, oEX_rs2_dt}), 64'd0);
    chk("clr_full", 64'(oINF_full), 64'd0);
    clr = 1'b0; rdy = 1'b1; iEX_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("clr_noissue%0d", c), 64'(oEX_en), 64'd0);
    end

    // T2/T4 and CDB corner cases from the vector table.
    for (int i = 0; i < 9; i++) begin
      idle();
      if (tbl[i].dp) dp(tbl[i].rd, tbl[i].n1, tbl[i].d1, tbl[i].n2, tbl[i].d2);
      if (tbl[i].cen[0]) cdb(0, tbl[i].cn0, tbl[i].cd0);
      if (tbl[i].cen[1]) cdb(1, tbl[i].cn1, tbl[i].cd1);
      tick();
      if (tbl[i].x_en) chk_ex($sformatf("tbl%0d", i), tbl[i].x_rd, tbl[i].x_d1, tbl[i].x_d2);
      else chk($sformatf("tbl%0d_en", i), 64'(oEX_en), 64'd0);
      chk($sformatf("tbl%0d_full", i), 64'(oINF_full), 64'd0);
    end

    // T3: wakeup on channel 1.
    idle(); dp(4'd10, 4'd9, 32'h0, 4'd0, 32'h20); tick();
    chk("t3_wait0", 64'(oEX_en), 64'd0);
    idle(); tick();
    chk("t3_wait1", 64'(oEX_en), 64'd0);
    cdb(1, 4'd9, 32'hDEAD); tick(); idle();
`ifdef RS_WAKEUP_BYPASS_EN
    chk_ex("t3_issue", 4'd10, 32'hDEAD, 32'h20);
    tick();
    chk("t3_after", 64'(oEX_en), 64'd0);
`else
    chk("t3_bubble", 64'(oEX_en), 64'd0);
    tick();
    chk_ex("t3_issue", 4'd10, 32'hDEAD, 32'h20);
`endif
    tick();
    chk("t3_drained", 64'(oEX_en), 64'd0);

    // T5: backpressure with two ready entries.
    iEX_ready = 1'b0;
    dp(4'd11, 4'd0, 32'h1, 4'd0, 32'h2); tick();
    chk("t5_first", 64'(oEX_en), 64'd0);
    dp(4'd12, 4'd0, 32'h3, 4'd0, 32'h4); tick(); idle();
    chk_ex("t5_load", 4'd11, 32'h1, 32'h2);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_ex($sformatf("t5_hold%0d", c), 4'd11, 32'h1, 32'h2);
    end
    iEX_ready = 1'b1; tick();
    chk_ex("t5_second", 4'd12, 32'h3, 32'h4);
    tick();
    chk("t5_empty", 64'(oEX_en), 64'd0);

    // T6: fill to DEPTH-1, illegal dispatch while full, drain with a 3-cycle freeze.
    for (int i = 0; i < 15; i++) begin
      dp(4'(i), 4'd14, 32'h0, 4'd0, 32'(i)); tick();
      if (i == 13) chk("t6_full_at14", 64'(oINF_full), 64'd0);
      if (i == 14) chk("t6_full_at15", 64'(oINF_full), 64'd1);
    end
    chk("t6_no_issue", 64'(oEX_en), 64'd0);
    dp(4'd15, 4'd14, 32'h0, 4'd0, 32'h0); tick(); idle();
    chk("t6_full_hold", 64'(oINF_full), 64'd1);
    cdb(0, 4'd14, 32'hE0E0); tick(); idle();
`ifdef RS_WAKEUP_BYPASS_EN
    chk_ex("t6_issue0", 4'd0, 32'hE0E0, 32'h0);
    chk("t6_full_drop", 64'(oINF_full), 64'd0);
`else
    chk("t6_wake_en", 64'(oEX_en), 64'd0);
    chk("t6_wake_full", 64'(oINF_full), 64'd1);
    tick();
    chk_ex("t6_issue0", 4'd0, 32'hE0E0, 32'h0);
    chk("t6_full_drop", 64'(oINF_full), 64'd0);
`endif
    rdy = 1'b0;
    dp(4'd15, 4'd0, 32'h0, 4'd0, 32'h0);
    cdb(1, 4'd14, 32'h1234);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_ex($sformatf("t6_frozen%0d", c), 4'd0, 32'hE0E0, 32'h0);
      chk($sformatf("t6_frozen_full%0d", c), 64'(oINF_full), 64'd0);
    end
    rdy = 1'b1; idle();
    for (int r = 1; r < 15; r++) begin
      tick();
      chk_ex($sformatf("t6_drain%0d", r), 4'(r), 32'hE0E0, 32'(r));
    end
    tick();
    chk("t6_drained", 64'(oEX_en), 64'd0);
    chk("t6_final_full", 64'(oINF_full), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
